// File: rtl/alu_mult_seq.sv
// Unsigned WIDTHxWIDTH shift-and-add multiplier that borrows the CPU ripple ALU as its only adder.
// Latency: start accepted in IDLE -> done pulse WIDTH+1 cycles later; one multiply per WIDTH+2 cycles.
// Backpressure: none; start is only honoured in IDLE and is dropped (not queued) while busy or done.
module alu_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry_out
);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CNT_W-1:0] cnt;
  logic             last_iter;

  // cnt counts completed iterations; the update at cnt==WIDTH-1 is the final one.
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // State register; reset abandons any multiply in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus ALU drive; the ALU sees zeros and AND outside CALC so it idles deterministically.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    alu_op    = ALU_AND;
    alu_a     = '0;
    alu_b     = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy   = 1'b1;
        alu_op = ALU_ADD;
        alu_a  = hi;
        alu_b  = lo[0] ? mcand_r : '0;
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture and per-iteration shift of {carry, sum, lo}; the carry becomes hi's MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_r <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
    end else if (state == IDLE && start) begin
      mcand_r <= multiplicand;
      hi      <= '0;
      lo      <= multiplier;
      cnt     <= '0;
    end else if (state == CALC) begin
      hi  <= {alu_carry_out, alu_result[WIDTH-1:1]};
      lo  <= {alu_result[0], lo[WIDTH-1:1]};
      cnt <= cnt + 1'b1;
    end
  end

  assign product_hi = hi;
  assign product_lo = lo;

endmodule

// File: tb/tb_alu_mult_seq.sv
module tb_alu_mult_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic         busy;
  logic         done;
  logic [W-1:0] product_hi;
  logic [W-1:0] product_lo;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_result;
  logic         alu_carry_out;
  logic [W:0]   alu_full;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mult_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .multiplicand  (multiplicand),
    .multiplier    (multiplier),
    .busy          (busy),
    .done          (done),
    .product_hi    (product_hi),
    .product_lo    (product_lo),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .alu_result    (alu_result),
    .alu_carry_out (alu_carry_out)
  );

  // Behavioural CPU ALU: bit W of alu_full is the carry out of the MSB slice.
  always_comb begin
    alu_full = '0;
    case (alu_op)
      3'b000: alu_full = {1'b0, alu_a & alu_b};
      3'b001: alu_full = {1'b0, alu_a | alu_b};
      3'b010: alu_full = {1'b0, alu_a} + {1'b0, alu_b};
      3'b110: alu_full = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      3'b111: alu_full = {{W{1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: alu_full = '0;
    endcase
  end
  assign alu_result    = alu_full[W-1:0];
  assign alu_carry_out = alu_full[W];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One multiply from IDLE, checked cycle by cycle against the documented timeline.
  // inj1/inj2 name cycles during which a competing start with junk operands is raised.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj1, input int inj2, input string tag);
    logic [63:0] exp_prod;
    logic        exp_busy;
    int          done_cnt;
    exp_prod     = 64'(a) * 64'(b);
    done_cnt     = 0;
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    for (int cyc = 1; cyc <= W + 4; cyc++) begin
      @(negedge clk);
      exp_busy = (cyc <= W);
      chk({tag, ":busy"}, 64'(busy), 64'(exp_busy));
      chk({tag, ":done"}, 64'(done), 64'(cyc == W + 1));
      chk({tag, ":alu_op"}, 64'(alu_op), exp_busy ? 64'd2 : 64'd0);
      if (!exp_busy) begin
        chk({tag, ":alu_a_idle"}, 64'(alu_a), 64'd0);
        chk({tag, ":alu_b_idle"}, 64'(alu_b), 64'd0);
      end else if (a == '0) begin
        chk({tag, ":alu_b_zero"}, 64'(alu_b), 64'd0);
      end
      if (cyc == W + 1 || cyc == W + 2) begin
        chk({tag, ":product"}, {product_hi, product_lo}, exp_prod);
      end
      if (done) done_cnt++;
      if (cyc == inj1 || cyc == inj2) begin
        start        = 1'b1;
        multiplicand = $urandom;
        multiplier   = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    chk({tag, ":done_count"}, 64'(done_cnt), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    int           cyc_ctr;
    int           last_done;
    int           waited;
    logic         got;

    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(negedge clk);
    chk("rst:busy", 64'(busy), 64'd0);
    chk("rst:done", 64'(done), 64'd0);
    chk("rst:hi", 64'(product_hi), 64'd0);
    chk("rst:lo", 64'(product_lo), 64'd0);
    chk("rst:alu_a", 64'(alu_a), 64'd0);
    chk("rst:alu_b", 64'(alu_b), 64'd0);
    chk("rst:alu_op", 64'(alu_op), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(32'd3, 32'd5, -1, -1, "basic");
    chk("basic:lo15", 64'(product_lo), 64'd15);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, "carry");
    chk("carry:hi", 64'(product_hi), 64'hFFFF_FFFE);
    chk("carry:lo", 64'(product_lo), 64'h0000_0001);
    run_op(32'd0, 32'h1234_5678, -1, -1, "zero_a");
    run_op(32'h1234_5678, 32'd0, -1, -1, "zero_b");
    run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 5, W + 1, "start_busy");

    // Reset at cycle 10 of a multiply discards it.
    start        = 1'b1;
    multiplicand = 32'h8000_0000;
    multiplier   = 32'd2;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("midrst:busy", 64'(busy), 64'd0);
    chk("midrst:done", 64'(done), 64'd0);
    chk("midrst:product", {product_hi, product_lo}, 64'd0);
    chk("midrst:alu_op", 64'(alu_op), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    run_op(32'h8000_0000, 32'd2, -1, -1, "after_rst");
    chk("after_rst:hi", 64'(product_hi), 64'd1);
    chk("after_rst:lo", 64'(product_lo), 64'd0);

    // Back-to-back with start held high: operands shown only around acceptance, junk otherwise.
    ea           = $urandom;
    eb           = $urandom;
    start        = 1'b1;
    multiplicand = ea;
    multiplier   = eb;
    cyc_ctr      = 0;
    last_done    = 0;
    for (int n = 0; n < 1000; n++) begin
      waited = 0;
      got    = 1'b0;
      while (!got && waited < 40) begin
        @(negedge clk);
        cyc_ctr++;
        waited++;
        if (done) begin
          got = 1'b1;
        end else if (waited == 2) begin
          multiplicand = $urandom;
          multiplier   = $urandom;
        end
      end
      checks++;
      assert (got) else begin
        errors++;
        $error("FAIL rand:timeout observed=no_done expected=done op=%0d", n);
      end
      if (!got) break;
      chk("rand:product", {product_hi, product_lo}, 64'(ea) * 64'(eb));
      if (n > 0) chk("rand:spacing", 64'(cyc_ctr - last_done), 64'd34);
      last_done = cyc_ctr;
      ea = $urandom;
      eb = $urandom;
      if (n % 97 == 3) ea = '1;
      if (n % 89 == 5) eb = '1;
      if (n % 83 == 7) eb = '0;
      multiplicand = ea;
      multiplier   = eb;
    end
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("end:busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mult_seq.md
# alu_mult_seq

Multi-cycle unsigned multiplier sequencer that reuses the CPU's 32-bit ripple ALU as its only adder. It implements the shift-and-add algorithm and issues one ALU add per cycle. On each add it drives the ALU operands and `ALUop`, and captures the result and carry-out. It sits beside the ALU in the datapath and produces a 2×WIDTH-bit product for a multi-cycle `mult` instruction.

## Interface

Parameters:
- `WIDTH`, 32, operand width; must match the ALU width.
- `CNT_W`, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `multiplicand`  in  WIDTH  operand A; captured when `start` is accepted.
- `multiplier`  in  WIDTH  operand B; captured when `start` is accepted.
- `busy`  out  1  high while in CALC.
- `done`  out  1  one-cycle pulse; product valid.
- `product_hi`  out  WIDTH  upper half of the product.
- `product_lo`  out  WIDTH  lower half of the product.
- `alu_a`  out  WIDTH  ALU operand a.
- `alu_b`  out  WIDTH  ALU operand b.
- `alu_op`  out  3  ALU control; bit 2 = b-invert/carry-in.
  - Encoding: 000 AND, 001 OR, 010 add, 110 subtract, 111 set-on-less-than.
- `alu_result`  in  WIDTH  combinational ALU result for the current operands.
- `alu_carry_out`  in  1  carry out of the ALU's MSB slice.

## Operation

- State machine: IDLE, CALC, DONE.
- IDLE:
  - `start`=1 loads mcand_r←`multiplicand`, hi←0, lo←`multiplier`, cnt←0, then goes to CALC.
  - `start`=0 stays in IDLE, holding all registers.
- CALC, one iteration per cycle:
  - `alu_op`=010, `alu_a`=hi, `alu_b`= lo[0] ? mcand_r : 0.
  - The register update shifts {`alu_carry_out`, `alu_result`, lo} right by one bit. The new hi is {`alu_carry_out`, `alu_result`[WIDTH-1:1]}. The new lo is {`alu_result`[0], lo[WIDTH-1:1]}.
  - cnt←cnt+1. When cnt==WIDTH-1, the update completes the last iteration and the FSM goes to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Outputs:
  - `product_hi`=hi and `product_lo`=lo at all times.
  - The values are meaningful when `done`=1 and are held unchanged until the next accepted `start`.
- Outside CALC, `alu_op`=000, `alu_a`=0 and `alu_b`=0, so the ALU sees deterministic idle inputs.
- `start` in CALC or DONE is ignored: no queuing, no restart, operands not captured.
- Arithmetic: unsigned WIDTH×WIDTH→2·WIDTH. The ALU carry-out is the (WIDTH+1)-th sum bit and must not be dropped. The ALU's overflow and set outputs are unused.
- Reset, in any state including mid-CALC:
  - State←IDLE; hi, lo, mcand_r and cnt←0.
  - `busy`=0, `done`=0, `alu_op`=000.
  - A partially computed product is discarded.

## Timing

- Reset values: `busy`=0, `done`=0, `product_hi`=0, `product_lo`=0, `alu_a`=0, `alu_b`=0, `alu_op`=000.
- Cycle numbering: `start` is sampled high in IDLE at edge 0.
  - CALC occupies cycles 1..WIDTH, with `busy`=1.
  - DONE occupies cycle WIDTH+1, with `done`=1 and `busy`=0.
  - IDLE resumes at cycle WIDTH+2.
- Latency: start to `done` = WIDTH+1 cycles (33 for WIDTH=32).
- Throughput: at most one multiply per WIDTH+2 cycles. A `start` held continuously is re-accepted at the first IDLE cycle.
- ALU path: `alu_a`, `alu_b` and `alu_op` are registered state or decoded from state. `alu_result` and `alu_carry_out` are consumed combinationally in the same cycle. The full ripple-carry path must close in one `clk` period.
- The multiplier has no exclusive claim on the ALU outside CALC. The top-level ALU input mux selects this block's outputs only while `busy`=1.

## Test plan

The bench models the ALU behaviourally: 010 = WIDTH-bit add with carry-out; other encodings as listed.

- Basic product: `start` with 3 × 5 → `done` at cycle 33; `product_hi`=0, `product_lo`=15; `busy` high exactly on cycles 1..32.
- Carry propagation: 0xFFFFFFFF × 0xFFFFFFFF → `product_hi`=0xFFFFFFFE, `product_lo`=0x00000001.
- Zero operand: 0 × 0x12345678 and 0x12345678 × 0 → product 0; `alu_b`=0 on every CALC cycle of the first case.
- Start while busy: second `start` with new operands at cycles 5 and 33 → ignored; product equals the first operation's result; `done` pulses once.
- Reset mid-operation: `reset` at cycle 10 of 0x80000000 × 2 → next cycle `busy`=0, products 0, `alu_op`=000. A following 0x80000000 × 2 → `product_hi`=1, `product_lo`=0.
- Back-to-back plus random: `start` held high for 1000 random operand pairs → each accepted in IDLE; products match a 64-bit reference model; `done` spacing is exactly 34 cycles.
